// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_read_port
//  Purpose  : Dual-operand register bank read port with a valid/ready request
//             side and a 2-entry (output + skid) response buffer. Operands are
//             muxed from r0..r15 in the accept cycle and frozen thereafter.
//             Optional macro RF_BYPASS_EN forwards ALUBus to an operand whose
//             register is being written in the accept cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_read_port #(
    parameter int ZERO_R0 = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] r0,
    input  logic [15:0] r1,
    input  logic [15:0] r2,
    input  logic [15:0] r3,
    input  logic [15:0] r4,
    input  logic [15:0] r5,
    input  logic [15:0] r6,
    input  logic [15:0] r7,
    input  logic [15:0] r8,
    input  logic [15:0] r9,
    input  logic [15:0] r10,
    input  logic [15:0] r11,
    input  logic [15:0] r12,
    input  logic [15:0] r13,
    input  logic [15:0] r14,
    input  logic [15:0] r15,
    input  logic [15:0] ALUBus,
    input  logic [15:0] regEnable,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  addrA,
    input  logic [3:0]  addrB,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] opA,
    output logic [15:0] opB
);

    // Buffer occupancy: output stage only, or output plus skid stage.
    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_TWO   = 2'd2;

    logic [1:0]  r_state;
    logic [15:0] r_out_a;
    logic [15:0] r_out_b;
    logic [15:0] r_skid_a;
    logic [15:0] r_skid_b;

    logic [15:0] w_bank [16];
    logic [15:0] w_op_a;
    logic [15:0] w_op_b;
    logic        w_accept;
    logic        w_pop;

    assign w_bank[0]  = r0;
    assign w_bank[1]  = r1;
    assign w_bank[2]  = r2;
    assign w_bank[3]  = r3;
    assign w_bank[4]  = r4;
    assign w_bank[5]  = r5;
    assign w_bank[6]  = r6;
    assign w_bank[7]  = r7;
    assign w_bank[8]  = r8;
    assign w_bank[9]  = r9;
    assign w_bank[10] = r10;
    assign w_bank[11] = r11;
    assign w_bank[12] = r12;
    assign w_bank[13] = r13;
    assign w_bank[14] = r14;
    assign w_bank[15] = r15;

`ifndef RF_BYPASS_EN
    // Write-side inputs only matter when bypass forwarding is built in.
    logic w_unused_write_side;
    assign w_unused_write_side = ^{ALUBus, regEnable};
`endif

    // Operand A select: bank value, optionally bypassed, with hard-zero r0 winning.
    always_comb begin
        w_op_a = w_bank[addrA];
`ifdef RF_BYPASS_EN
        if (regEnable[addrA]) begin
            w_op_a = ALUBus;
        end
`endif
        if ((ZERO_R0 != 0) && (addrA == 4'd0)) begin
            w_op_a = 16'h0000;
        end
    end

    // Operand B select: evaluated independently of operand A.
    always_comb begin
        w_op_b = w_bank[addrB];
`ifdef RF_BYPASS_EN
        if (regEnable[addrB]) begin
            w_op_b = ALUBus;
        end
`endif
        if ((ZERO_R0 != 0) && (addrB == 4'd0)) begin
            w_op_b = 16'h0000;
        end
    end

    // Ready drops combinationally with reset so nothing is accepted in a reset cycle.
    assign req_ready = (r_state != c_TWO) && !reset;
    assign rsp_valid = (r_state == c_ONE) || (r_state == c_TWO);
    assign opA       = r_out_a;
    assign opB       = r_out_b;

    assign w_accept  = req_valid && req_ready;
    assign w_pop     = rsp_valid && rsp_ready;

    // Buffer FSM: loads the output or skid stage on accept, shifts on pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_EMPTY;
            r_out_a  <= 16'h0000;
            r_out_b  <= 16'h0000;
            r_skid_a <= 16'h0000;
            r_skid_b <= 16'h0000;
        end else begin
            case (r_state)
                c_EMPTY: begin
                    if (w_accept) begin
                        r_out_a <= w_op_a;
                        r_out_b <= w_op_b;
                        r_state <= c_ONE;
                    end
                end
                c_ONE: begin
                    if (w_accept && w_pop) begin
                        r_out_a <= w_op_a;
                        r_out_b <= w_op_b;
                    end else if (w_accept) begin
                        r_skid_a <= w_op_a;
                        r_skid_b <= w_op_b;
                        r_state  <= c_TWO;
                    end else if (w_pop) begin
                        r_state <= c_EMPTY;
                    end
                end
                c_TWO: begin
                    if (w_pop) begin
                        r_out_a <= r_skid_a;
                        r_out_b <= r_skid_b;
                        r_state <= c_ONE;
                    end
                end
                default: begin
                    r_state <= c_EMPTY;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_read_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_read_port
//  Purpose  : Scoreboard bench for regfile_read_port. Two instances share all
//             inputs: one with ZERO_R0=0, one with ZERO_R0=1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_read_port;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] za;
        logic [15:0] zb;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [15:0] rf [16];
    logic [15:0] ALUBus;
    logic [15:0] regEnable;
    logic        req_valid;
    logic [3:0]  addrA;
    logic [3:0]  addrB;
    logic        rsp_ready;

    logic        req_ready,   z_req_ready;
    logic        rsp_valid,   z_rsp_valid;
    logic [15:0] opA, opB,    z_opA, z_opB;

    exp_t        sb [$];
    int          n_tests;
    int          n_fail;

    regfile_read_port #(.ZERO_R0(0)) dut (
        .clk(clk), .reset(reset),
        .r0(rf[0]), .r1(rf[1]), .r2(rf[2]), .r3(rf[3]),
        .r4(rf[4]), .r5(rf[5]), .r6(rf[6]), .r7(rf[7]),
        .r8(rf[8]), .r9(rf[9]), .r10(rf[10]), .r11(rf[11]),
        .r12(rf[12]), .r13(rf[13]), .r14(rf[14]), .r15(rf[15]),
        .ALUBus(ALUBus), .regEnable(regEnable),
        .req_valid(req_valid), .req_ready(req_ready),
        .addrA(addrA), .addrB(addrB),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .opA(opA), .opB(opB)
    );

    regfile_read_port #(.ZERO_R0(1)) dut_z (
        .clk(clk), .reset(reset),
        .r0(rf[0]), .r1(rf[1]), .r2(rf[2]), .r3(rf[3]),
        .r4(rf[4]), .r5(rf[5]), .r6(rf[6]), .r7(rf[7]),
        .r8(rf[8]), .r9(rf[9]), .r10(rf[10]), .r11(rf[11]),
        .r12(rf[12]), .r13(rf[13]), .r14(rf[14]), .r15(rf[15]),
        .ALUBus(ALUBus), .regEnable(regEnable),
        .req_valid(req_valid), .req_ready(z_req_ready),
        .addrA(addrA), .addrB(addrB),
        .rsp_valid(z_rsp_valid), .rsp_ready(rsp_ready),
        .opA(z_opA), .opB(z_opB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] a, input logic [3:0] b,
                         input logic [15:0] ea, input logic [15:0] eb,
                         input logic [15:0] eza, input logic [15:0] ezb);
        req_valid = 1'b1;
        addrA     = a;
        addrB     = b;
        sb.push_back('{ea, eb, eza, ezb});
    endtask

    // Monitor: every response handshake about to happen is checked against the queue head.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: got opA=%h opB=%h expected none", opA, opB);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_opA", opA, e.a);
                check("rsp_opB", opB, e.b);
                check("rsp_z_valid", {15'd0, z_rsp_valid}, 16'd1);
                check("rsp_z_opA", z_opA, e.za);
                check("rsp_z_opB", z_opB, e.zb);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        ALUBus    = 16'h0000;
        regEnable = 16'h0000;
        req_valid = 1'b0;
        addrA     = 4'd0;
        addrB     = 4'd0;
        rsp_ready = 1'b0;
        for (int k = 0; k < 16; k++) rf[k] = 16'h0000;

        // Reset state
        step();
        step();
        check("reset_rsp_valid", {15'd0, rsp_valid}, 16'd0);
        check("reset_req_ready", {15'd0, req_ready}, 16'd0);
        check("reset_opA", opA, 16'h0000);
        check("reset_opB", opB, 16'h0000);
        reset = 1'b0;
        #1;
        check("post_reset_ready", {15'd0, req_ready}, 16'd1);

        // Basic read, 1-cycle latency
        rf[3] = 16'h1234;
        rf[9] = 16'hBEEF;
        rsp_ready = 1'b1;
        issue(4'd3, 4'd9, 16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF);
        step();
        req_valid = 1'b0;
        check("latency_rsp_valid", {15'd0, rsp_valid}, 16'd1);
        step();
        check("drain_rsp_valid", {15'd0, rsp_valid}, 16'd0);

        // Fill to TWO with consumer stalled, hold, then drain in order
        rsp_ready = 1'b0;
        rf[1] = 16'h1111; rf[2] = 16'h2222; rf[4] = 16'h4444; rf[6] = 16'h6666;
        issue(4'd1, 4'd2, 16'h1111, 16'h2222, 16'h1111, 16'h2222);
        step();
        issue(4'd4, 4'd6, 16'h4444, 16'h6666, 16'h4444, 16'h6666);
        step();
        req_valid = 1'b0;
        check("two_req_ready", {15'd0, req_ready}, 16'd0);
        check("two_rsp_valid", {15'd0, rsp_valid}, 16'd1);
        check("two_opA_hold", opA, 16'h1111);
        rf[1] = 16'hDEAD;
        step();
        check("stall_opA_frozen", opA, 16'h1111);
        check("stall_opB_frozen", opB, 16'h2222);
        rsp_ready = 1'b1;
        step();
        check("drain_one_valid", {15'd0, rsp_valid}, 16'd1);
        step();
        check("drained_rsp_valid", {15'd0, rsp_valid}, 16'd0);
        check("drained_req_ready", {15'd0, req_ready}, 16'd1);

        // Bypass, independent ports, multi-hot enables
        rf[5] = 16'h0001;
        rf[7] = 16'h7777;
        ALUBus = 16'hCAFE;
        regEnable = 16'h0020;
`ifdef RF_BYPASS_EN
        issue(4'd5, 4'd7, 16'hCAFE, 16'h7777, 16'hCAFE, 16'h7777);
`else
        issue(4'd5, 4'd7, 16'h0001, 16'h7777, 16'h0001, 16'h7777);
`endif
        step();
        regEnable = 16'h00A0;
`ifdef RF_BYPASS_EN
        issue(4'd5, 4'd7, 16'hCAFE, 16'hCAFE, 16'hCAFE, 16'hCAFE);
`else
        issue(4'd5, 4'd7, 16'h0001, 16'h7777, 16'h0001, 16'h7777);
`endif
        step();

        // Address 0 with hard zero, with and without a write to r0
        rf[0] = 16'hFFFF;
        ALUBus = 16'h1357;
        regEnable = 16'h0001;
`ifdef RF_BYPASS_EN
        issue(4'd0, 4'd0, 16'h1357, 16'h1357, 16'h0000, 16'h0000);
`else
        issue(4'd0, 4'd0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000);
`endif
        step();
        regEnable = 16'h0000;
        issue(4'd0, 4'd0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000);
        step();
        req_valid = 1'b0;
        step();
        check("zero_drained", {15'd0, rsp_valid}, 16'd0);

        // Reset while holding two entries discards them
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        addrA = 4'd1; addrB = 4'd2;
        step();
        addrA = 4'd4; addrB = 4'd6;
        step();
        check("prereset_two_ready", {15'd0, req_ready}, 16'd0);
        reset = 1'b1;
        step();
        check("midreset_rsp_valid", {15'd0, rsp_valid}, 16'd0);
        check("midreset_req_ready", {15'd0, req_ready}, 16'd0);
        check("midreset_opA", opA, 16'h0000);
        check("midreset_opB", opB, 16'h0000);
        check("midreset_z_opA", z_opA, 16'h0000);
        reset = 1'b0;
        req_valid = 1'b0;
        #1;
        check("afterreset_req_ready", {15'd0, req_ready}, 16'd1);
        step();
        check("afterreset_rsp_valid", {15'd0, rsp_valid}, 16'd0);

        // Sustained throughput: 8 back-to-back requests
        for (int k = 1; k < 16; k++) rf[k] = 16'hA000 | 16'(k);
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [3:0] a, b;
            a = 4'(i + 1);
            b = 4'(15 - i);
            issue(a, b, 16'hA000 | 16'(a), 16'hA000 | 16'(b),
                  16'hA000 | 16'(a), 16'hA000 | 16'(b));
            step();
            check("stream_rsp_valid", {15'd0, rsp_valid}, 16'd1);
            check("stream_req_ready", {15'd0, req_ready}, 16'd1);
        end
        req_valid = 1'b0;
        step();
        check("stream_end_valid", {15'd0, rsp_valid}, 16'd0);
        check("scoreboard_empty", 16'(sb.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_read_port.md
REGFILE_READ_PORT -- requirements
Module: regfile_read_port

Interface
REQ-001 The block SHALL have parameter ZERO_R0, default 0, meaning: when 1, reads of address 0 return 16'h0000 regardless of r0.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock for all state.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports r0..r15, input, 16 each, the current register bank contents.
REQ-005 The block SHALL have port ALUBus, input, 16, the write data being presented to the register bank this cycle.
REQ-006 The block SHALL have port regEnable, input, 16, the write enables being presented to the register bank this cycle (bit i targets ri).
REQ-007 The block SHALL have port req_valid, input, 1, asserted when a read request is offered.
REQ-008 The block SHALL have port req_ready, output, 1, asserted when the block can accept a request.
REQ-009 The block SHALL have ports addrA and addrB, input, 4 each, the source register indices.
REQ-010 The block SHALL have port rsp_valid, output, 1, asserted when opA and opB hold a valid response.
REQ-011 The block SHALL have port rsp_ready, input, 1, asserted when the consumer takes the response.
REQ-012 The block SHALL have ports opA and opB, output, 16 each, the operand data for the response.

Function
REQ-013 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-014 A response SHALL be popped on a rising edge where rsp_valid and rsp_ready are both 1.
REQ-015 Operands SHALL be sampled at acceptance: data = r[addrA] and r[addrB], muxed in the accept cycle.
REQ-016 Operands SHALL be frozen after acceptance, so later bank changes do not alter a held response.
REQ-017 The block SHALL implement a 2-entry buffer (output stage plus skid stage) as an FSM with states EMPTY, ONE and TWO.
REQ-018 In EMPTY, accept SHALL load the output stage and go to ONE; with no accept the state SHALL hold.
REQ-019 In ONE, accept with pop SHALL load the output stage and stay in ONE.
REQ-020 In ONE, accept without pop SHALL load the skid stage and go to TWO.
REQ-021 In ONE, pop without accept SHALL go to EMPTY; with neither accept nor pop the state SHALL hold.
REQ-022 In TWO, pop SHALL move the skid stage to the output stage and go to ONE; with no pop the state SHALL hold.
REQ-023 Accept SHALL be impossible in TWO.
REQ-024 req_ready SHALL be 1 exactly when the state is not TWO and reset is 0.
REQ-025 rsp_valid SHALL be 1 exactly when the state is ONE or TWO.
REQ-026 Latency SHALL be 1 cycle: a request accepted at edge N into EMPTY gives rsp_valid=1 after edge N.
REQ-027 Sustained throughput SHALL be 1 request per cycle while rsp_ready=1.
REQ-028 opA and opB SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-029 Responses SHALL be delivered in acceptance order with no loss or duplication.
REQ-030 When ZERO_R0=1 and the address is 0, the operand SHALL be 16'h0000, taking priority over bypass.
REQ-031 addrA equal to addrB SHALL be legal, and both operands SHALL then receive identical data.
REQ-032 A multi-hot regEnable SHALL be legal: each port is evaluated independently on its own address bit.

Reset
REQ-033 When reset=1 at an edge, the next state SHALL be EMPTY and opA=opB=16'h0000, with the skid stage cleared.
REQ-034 When reset=1 at an edge, rsp_valid SHALL be 0 and req_ready SHALL be 0 while reset is high.
REQ-035 Reset mid-operation SHALL discard all buffered responses, and no request SHALL be accepted in a reset cycle.
REQ-036 req_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-037 Macro RF_BYPASS_EN, when defined, SHALL make an operand equal ALUBus if regEnable[addr]=1 in the accept cycle, giving the post-write value.
REQ-038 When RF_BYPASS_EN is undefined, operands SHALL be the pre-write r[addr] values, and ALUBus and regEnable SHALL be unused.

Verification
REQ-039 The bench SHALL cover: r3=16'h1234, r9=16'hBEEF, req addrA=3 addrB=9 into EMPTY -> next cycle rsp_valid=1, opA=1234, opB=BEEF.
REQ-040 The bench SHALL cover: rsp_ready=0, two requests A then B -> state TWO, req_ready=0, opA holds A data; rsp_ready=1 for 2 cycles -> A then B delivered, then EMPTY.
REQ-041 The bench SHALL cover: r5=0001, regEnable=16'h0020, ALUBus=16'hCAFE, accept addrA=5 -> opA=CAFE with RF_BYPASS_EN, opA=0001 without.
REQ-042 The bench SHALL cover: ZERO_R0=1, r0=FFFF, addrA=0, addrB=0 -> opA=opB=0000, including when regEnable[0]=1 with RF_BYPASS_EN.
REQ-043 The bench SHALL cover: state TWO, reset=1 for one cycle -> rsp_valid=0, opA=opB=0000, req_ready=0 during reset and 1 after.
REQ-044 The bench SHALL cover: req_valid=1 and rsp_ready=1 held for 8 cycles with distinct addresses -> 8 responses on consecutive cycles, in order.
